word_unpacker: RTL and testbench
================================

WORD_UNPACKER -- requirements
Module: word_unpacker

Interface
REQ-001 Parameter LETTERS, default 5: number of letters per packed word.
REQ-002 Parameter LETTER_W, default 8: bits per letter (ASCII); packed width W = LETTERS*LETTER_W (40 at defaults).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 clr  input  1  reset; asynchronous, active-high.
REQ-005 ie  input  1  load request; word on indata is accepted when ie=1 and in_ready=1 at a rising edge.
REQ-006 indata  input  W  packed word; letter k occupies bits [k*LETTER_W+LETTER_W-1 : k*LETTER_W].
REQ-007 in_ready  output  1  high only in IDLE; the block can accept a word.
REQ-008 out  output  LETTER_W  current letter presented to the consumer.
REQ-009 out_valid  output  1  out holds a valid letter.
REQ-010 out_ready  input  1  consumer accepts out this cycle.
REQ-011 idx  output  3  index of the letter currently on out, 0..LETTERS-1.
REQ-012 done  output  1  one-cycle pulse after the last letter transfers.

Function
REQ-013 States: IDLE, SEND, DONE; encoding is implementation choice.
REQ-014 IDLE: in_ready=1, out_valid=0, idx=0, done=0; out holds 0.
REQ-015 IDLE and ie=1 at edge: capture indata into internal W-bit holding register, idx<=0, go to SEND; out_valid=1 from the next cycle (1-cycle load-to-valid latency).
REQ-016 IDLE and ie=0: remain in IDLE, holding register unchanged.
REQ-017 SEND: out_valid=1, out = letter idx of the captured word; letter 0 first (LSB letter first).
REQ-018 Transfer occurs at an edge where out_valid=1 and out_ready=1.
REQ-019 SEND with out_ready=0: out, idx, out_valid held stable, no letter skipped or repeated.
REQ-020 Transfer with idx<LETTERS-1: idx<=idx+1, next letter on out the following cycle; back-to-back transfers at one letter per cycle when out_ready stays 1.
REQ-021 Transfer with idx=LETTERS-1: go to DONE, out_valid<=0.
REQ-022 DONE: done=1 for exactly one cycle, out_valid=0, in_ready=0; unconditional transition to IDLE next edge.
REQ-023 ie is ignored in SEND and DONE; captured word cannot be modified while unpacking; indata changes after capture have no effect.
REQ-024 Exactly LETTERS transfers occur per accepted word; minimum accept-to-next-accept spacing is LETTERS+2 cycles.
REQ-025 out_ready while out_valid=0 has no effect.
REQ-026 idx never exceeds LETTERS-1; no wrap-around to 0 within a word.

Reset
REQ-027 clr=1 forces immediately (no clock required): state IDLE, holding register 0, out=0, out_valid=0, idx=0, done=0, in_ready=1.
REQ-028 clr asserted mid-SEND discards the remaining letters; no done pulse is produced for the aborted word.
REQ-029 clr has priority over ie and out_ready at the same edge; the first word can be accepted on the first edge after clr deasserts.

Verification
REQ-030 Reset: assert clr mid-cycle with no clock -> out=0, out_valid=0, idx=0, done=0, in_ready=1 immediately.
REQ-031 Basic "CRANE": indata=40'h454E415243, ie=1 for one edge, out_ready=1 -> out sequence 8'h43,8'h52,8'h41,8'h4E,8'h45 on 5 consecutive cycles, idx 0..4, then done=1 one cycle, then in_ready=1.
REQ-032 Backpressure: same word, out_ready=0 for 3 cycles while idx=2 -> out held at 8'h41, idx held at 2; resumes with 8'h4E; still exactly 5 transfers.
REQ-033 Load ignored: during SEND apply ie=1 with indata=40'h4554414C53 ("SLATE") -> the CRANE sequence is unaffected; SLATE is accepted only if presented again while in_ready=1.
REQ-034 Reset mid-operation: clr pulse after 2 transfers of CRANE -> out_valid=0 at once, no done pulse; a new load of SLATE emits 8'h53,8'h4C,8'h41,8'h54,8'h45.
REQ-035 Back-to-back words: ie held high with CRANE then SLATE -> second word accepted on the first edge in IDLE after the done pulse; 10 letters total in order, 2 done pulses.

Source files
------------

// File: rtl/word_unpacker.sv
// Unpacks a captured word of LETTERS letters and presents them one per
// transfer (LSB letter first) on a valid/ready stream, then pulses done.
module word_unpacker #(
  parameter int LETTERS  = 5,
  parameter int LETTER_W = 8
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        ie,
  input  logic [LETTERS*LETTER_W-1:0] indata,
  output logic                        in_ready,
  output logic [LETTER_W-1:0]         out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [2:0]                  idx,
  output logic                        done
);

  localparam int W = LETTERS * LETTER_W;
  localparam logic [2:0] LAST = 3'(LETTERS - 1);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t         state, nxt;
  logic [W-1:0]   word;
  logic           xfer;

  assign xfer = (state == SEND) && out_ready;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= nxt;
  end

  // idx returns to 0 on the final transfer so it already reads 0 in DONE/IDLE
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      word <= '0;
      idx  <= '0;
    end else if (state == IDLE && ie) begin
      word <= indata;
      idx  <= '0;
    end else if (xfer) begin
      idx <= (idx == LAST) ? 3'd0 : idx + 3'd1;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (ie) nxt = SEND;
      SEND:    if (xfer && idx == LAST) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == SEND);
  assign done      = (state == DONE);

  always_comb begin
    out = '0;
    if (state == SEND) begin
      for (int k = 0; k < LETTERS; k++) begin
        if (idx == 3'(k)) out = word[k*LETTER_W +: LETTER_W];
      end
    end
  end

endmodule

// File: tb/tb_word_unpacker.sv
// Testbench for word_unpacker: directed CRANE/SLATE scenarios plus random
// traffic, all checked against a queue-based letter model.
module tb_word_unpacker;

  localparam int LETTERS  = 5;
  localparam int LETTER_W = 8;
  localparam int W        = LETTERS * LETTER_W;

  localparam logic [W-1:0] CRANE = 40'h454E415243;
  localparam logic [W-1:0] SLATE = 40'h4554414C53;

  logic                clk;
  logic                clr;
  logic                ie;
  logic [W-1:0]        indata;
  logic                in_ready;
  logic [LETTER_W-1:0] out;
  logic                out_valid;
  logic                out_ready;
  logic [2:0]          idx;
  logic                done;

  int checkCount = 0;
  int failCount  = 0;

  // Model: letters still owed to the consumer, and a pending done pulse
  logic [LETTER_W-1:0] expQ[$];
  bit                  donePend = 0;

  // Observed transfers and done pulses for the current scenario
  logic [LETTER_W-1:0] trace[$];
  int                  doneCount = 0;

  word_unpacker #(.LETTERS(LETTERS), .LETTER_W(LETTER_W)) dut (
    .clk(clk), .clr(clr), .ie(ie), .indata(indata), .in_ready(in_ready),
    .out(out), .out_valid(out_valid), .out_ready(out_ready), .idx(idx), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checkCount++;
    if (got !== want) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic compareAll();
    bit busy;
    busy = (expQ.size() != 0);
    checkOutput("in_ready", 64'(in_ready), 64'(!busy && !donePend));
    checkOutput("out_valid", 64'(out_valid), 64'(busy));
    checkOutput("out", 64'(out), busy ? 64'(expQ[0]) : 64'd0);
    checkOutput("idx", 64'(idx), busy ? 64'(LETTERS - expQ.size()) : 64'd0);
    checkOutput("done", 64'(done), 64'(donePend));
  endtask

  task automatic modelStep(input logic i, input logic [W-1:0] d, input logic r);
    if (donePend) begin
      donePend = 0;
    end else if (expQ.size() != 0) begin
      if (r) begin
        void'(expQ.pop_front());
        if (expQ.size() == 0) donePend = 1;
      end
    end else if (i) begin
      for (int k = 0; k < LETTERS; k++) expQ.push_back(LETTER_W'(d >> (k * LETTER_W)));
    end
  endtask

  // One clock cycle: drive inputs, clock edge, update model, check at negedge
  task automatic applyStimulus(input logic i, input logic [W-1:0] d, input logic r);
    ie = i; indata = d; out_ready = r;
    if (out_valid && r) trace.push_back(out);
    @(posedge clk);
    modelStep(i, d, r);
    @(negedge clk);
    compareAll();
    if (done) doneCount++;
  endtask

  // Asynchronous clear in the low phase, checked before any clock edge
  task automatic asyncReset();
    #2;
    clr = 1'b1;
    #1;
    expQ.delete();
    donePend = 0;
    compareAll();
    @(negedge clk);
    clr = 1'b0;
    compareAll();
  endtask

  task automatic startScenario();
    trace.delete();
    doneCount = 0;
  endtask

  task automatic checkTrace(input string tag, input logic [W-1:0] w1, input logic [W-1:0] w2, input int nWords);
    logic [LETTER_W-1:0] want[$];
    for (int k = 0; k < LETTERS; k++) want.push_back(LETTER_W'(w1 >> (k * LETTER_W)));
    if (nWords > 1)
      for (int k = 0; k < LETTERS; k++) want.push_back(LETTER_W'(w2 >> (k * LETTER_W)));
    checkOutput({tag, "_count"}, 64'(trace.size()), 64'(want.size()));
    for (int k = 0; k < want.size() && k < trace.size(); k++)
      checkOutput({tag, "_letter"}, 64'(trace[k]), 64'(want[k]));
  endtask

  initial begin
    logic [LETTER_W-1:0] craneL[LETTERS];
    logic [63:0]         rnd;
    craneL = '{8'h43, 8'h52, 8'h41, 8'h4E, 8'h45};

    clr = 1'b1; ie = 1'b0; indata = '0; out_ready = 1'b0;
    #3;
    compareAll();
    @(negedge clk);
    clr = 1'b0;
    compareAll();

    $display("[TB] basic CRANE");
    startScenario();
    applyStimulus(1'b1, CRANE, 1'b1);
    for (int k = 0; k < LETTERS; k++) begin
      checkOutput("crane_out", 64'(out), 64'(craneL[k]));
      checkOutput("crane_idx", 64'(idx), 64'(k));
      applyStimulus(1'b0, '0, 1'b1);
    end
    checkOutput("crane_done", 64'(done), 64'd1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("crane_in_ready", 64'(in_ready), 64'd1);
    checkTrace("crane", CRANE, '0, 1);
    checkOutput("crane_dones", 64'(doneCount), 64'd1);

    $display("[TB] backpressure with ignored SLATE load");
    startScenario();
    applyStimulus(1'b1, CRANE, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, SLATE, 1'b0);
      checkOutput("bp_out", 64'(out), 64'h41);
      checkOutput("bp_idx", 64'(idx), 64'd2);
    end
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, SLATE, 1'b1);
    checkTrace("bp", CRANE, '0, 1);
    checkOutput("bp_dones", 64'(doneCount), 64'd1);
    startScenario();
    applyStimulus(1'b1, SLATE, 1'b1);
    for (int k = 0; k < LETTERS + 1; k++) applyStimulus(1'b0, '0, 1'b1);
    checkTrace("slate", SLATE, '0, 1);

    $display("[TB] reset mid-operation");
    startScenario();
    applyStimulus(1'b1, CRANE, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    asyncReset();
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    startScenario();
    applyStimulus(1'b0, '0, 1'b1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("rst_no_done", 64'(doneCount), 64'd0);
    applyStimulus(1'b1, SLATE, 1'b1);
    for (int k = 0; k < LETTERS + 1; k++) applyStimulus(1'b0, '0, 1'b1);
    checkTrace("rst_slate", SLATE, '0, 1);

    $display("[TB] back-to-back words");
    startScenario();
    applyStimulus(1'b1, CRANE, 1'b1);
    for (int k = 0; k < LETTERS + 2; k++) applyStimulus(1'b1, SLATE, 1'b1);
    for (int k = 0; k < LETTERS + 2; k++) applyStimulus(1'b0, '0, 1'b1);
    checkTrace("b2b", CRANE, SLATE, 2);
    checkOutput("b2b_dones", 64'(doneCount), 64'd2);

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        asyncReset();
      end else begin
        rnd = {$urandom(), $urandom()};
        applyStimulus($urandom_range(0, 2) == 0, rnd[W-1:0], $urandom_range(0, 3) != 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
